// File: rtl/clk_enable_gen.sv
// rtl/clk_enable_gen.sv - loadable main/sub clock-enable generator with run, re-sync and load checking
// Optional drift capture of the main counter at sync_in: define SYNC_CAPTURE_EN.
module clk_enable_gen #(
  parameter int CNT_W       = 26,
  parameter int DIV_DEFAULT = 10000000,
  parameter int SUB_DEFAULT = 1000000
) (
  input  logic             clk10,
  input  logic             reset,
  input  logic             run,
  input  logic             sync_in,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic [CNT_W-1:0] sub_value,
  output logic             clk_enable,
  output logic             sub_enable,
  output logic [CNT_W-1:0] phase,
  output logic             load_err,
  output logic [CNT_W-1:0] sync_phase,
  output logic             sync_valid
);

  localparam logic [CNT_W-1:0] ZERO     = '0;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] SUB_INIT = CNT_W'(SUB_DEFAULT);

  logic [CNT_W-1:0] cnt, sub_cnt;
  logic [CNT_W-1:0] div_act, sub_act;
  logic [CNT_W-1:0] div_sh, sub_sh;
  logic             pending;
  logic             wrap, sub_wrap, load_ok, apply;

  always_comb begin
    wrap     = (cnt == div_act - ONE);
    sub_wrap = (sub_cnt == sub_act - ONE);
    load_ok  = (div_value >= TWO) && (sub_value != ZERO) && (sub_value <= div_value);
    apply    = pending && (sync_in || (run && wrap));
  end

  always_ff @(posedge clk10 or negedge reset) begin
    if (!reset) begin
      cnt        <= ZERO;
      sub_cnt    <= ZERO;
      div_act    <= DIV_INIT;
      sub_act    <= SUB_INIT;
      div_sh     <= DIV_INIT;
      sub_sh     <= SUB_INIT;
      pending    <= 1'b0;
      clk_enable <= 1'b0;
      sub_enable <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      clk_enable <= 1'b0;
      sub_enable <= 1'b0;
      load_err   <= 1'b0;

      // Re-sync and main wrap both realign the sub counter, so one pulse covers both.
      if (sync_in || (run && wrap)) begin
        cnt        <= ZERO;
        sub_cnt    <= ZERO;
        clk_enable <= 1'b1;
        sub_enable <= 1'b1;
      end else if (run) begin
        cnt <= cnt + ONE;
        if (sub_wrap) begin
          sub_cnt    <= ZERO;
          sub_enable <= 1'b1;
        end else begin
          sub_cnt <= sub_cnt + ONE;
        end
      end

      if (apply) begin
        div_act <= div_sh;
        sub_act <= sub_sh;
        pending <= 1'b0;
      end

      // A load on the same edge as an application re-arms pending for the next wrap.
      if (div_load) begin
        if (load_ok) begin
          div_sh  <= div_value;
          sub_sh  <= sub_value;
          pending <= 1'b1;
        end else begin
          load_err <= 1'b1;
        end
      end
    end
  end

  assign phase = cnt;

`ifdef SYNC_CAPTURE_EN
  always_ff @(posedge clk10 or negedge reset) begin
    if (!reset) begin
      sync_phase <= ZERO;
      sync_valid <= 1'b0;
    end else begin
      sync_valid <= sync_in;
      if (sync_in) sync_phase <= cnt;
    end
  end
`else
  assign sync_phase = ZERO;
  assign sync_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clk_enable_gen.sv
// tb/tb_clk_enable_gen.sv - scoreboard bench for clk_enable_gen (DIV_DEFAULT=10, SUB_DEFAULT=3)
module tb_clk_enable_gen;

  localparam int W = 26;
`ifdef SYNC_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic         clk10 = 1'b0;
  logic         reset = 1'b0;
  logic         run = 1'b0, sync_in = 1'b0, div_load = 1'b0;
  logic [W-1:0] div_value = '0, sub_value = '0;
  logic         clk_enable, sub_enable, load_err, sync_valid;
  logic [W-1:0] phase, sync_phase;

  clk_enable_gen #(.CNT_W(W), .DIV_DEFAULT(10), .SUB_DEFAULT(3)) dut (
    .clk10(clk10), .reset(reset), .run(run), .sync_in(sync_in),
    .div_load(div_load), .div_value(div_value), .sub_value(sub_value),
    .clk_enable(clk_enable), .sub_enable(sub_enable), .phase(phase),
    .load_err(load_err), .sync_phase(sync_phase), .sync_valid(sync_valid)
  );

  always #5 clk10 = ~clk10;

  // Edges since reset release; sampled on the falling edge it equals the edge just taken.
  int k;
  always @(posedge clk10 or negedge reset) begin
    if (!reset) k <= 0;
    else        k <= k + 1;
  end

  typedef struct {
    int           k;
    logic [3:0]   flags;   // {clk_enable, sub_enable, load_err, sync_valid}
    logic [W-1:0] sp;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  task automatic push(input int kk, input bit ce, input bit se,
                      input bit le = 1'b0, input bit sv = 1'b0, input int sp = 0);
    exp_t e;
    e.k     = kk;
    e.flags = {ce, se, le, sv & CAP};
    e.sp    = W'(sp);
    q.push_back(e);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the scoreboard.
  always @(negedge clk10) begin
    if (reset && (clk_enable || sub_enable || load_err || sync_valid)) begin
      if (q.size() == 0) begin
        check($sformatf("unexpected_pulse_k%0d", k), {clk_enable, sub_enable, load_err, sync_valid}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_edge", k, e.k);
        check($sformatf("pulse_flags_k%0d", e.k), {clk_enable, sub_enable, load_err, sync_valid}, e.flags);
        if (CAP && e.flags[0]) check("sync_phase", sync_phase, e.sp);
      end
    end
  end

  task automatic goto(input int n);
    int guard = 0;
    while (k < n && guard < 400) begin
      @(negedge clk10);
      guard++;
    end
    if (k < n) check("timeout", k, n);
  endtask

  task automatic start_test;
    reset = 1'b0; run = 1'b0; sync_in = 1'b0; div_load = 1'b0;
    repeat (2) @(negedge clk10);
    check("reset_outputs", {clk_enable, sub_enable, load_err, sync_valid}, 0);
    check("reset_phase", phase, 0);
    check("reset_sync_phase", sync_phase, 0);
    reset = 1'b1;
    run   = 1'b1;
  endtask

  task automatic end_test(input string name, input int n);
    goto(n);
    check({name, "_queue_empty"}, q.size(), 0);
    q.delete();
  endtask

  task automatic load_at(input int e, input int dv, input int sv);
    goto(e - 1);
    div_load = 1'b1; div_value = W'(dv); sub_value = W'(sv);
    goto(e);
    div_load = 1'b0;
  endtask

  task automatic push_default_21;
    push(3, 0, 1); push(6, 0, 1); push(9, 0, 1); push(10, 1, 1);
    push(13, 0, 1); push(16, 0, 1); push(19, 0, 1); push(20, 1, 1);
  endtask

  initial begin
    // 1: default periods
    start_test();
    push_default_21();
    end_test("t1", 21);

    // 2: load 5/2 at edge 4, applied at the edge-10 wrap
    start_test();
    push(3, 0, 1); push(6, 0, 1); push(9, 0, 1); push(10, 1, 1);
    push(12, 0, 1); push(14, 0, 1); push(15, 1, 1); push(17, 0, 1);
    push(19, 0, 1); push(20, 1, 1);
    load_at(4, 5, 2);
    end_test("t2", 21);

    // 3: rejected loads leave the period at 10
    start_test();
    push(3, 0, 1); push(4, 0, 0, 1); push(6, 0, 1); push(7, 0, 0, 1);
    push(9, 0, 1); push(10, 1, 1); push(13, 0, 1); push(16, 0, 1);
    push(19, 0, 1); push(20, 1, 1);
    load_at(4, 1, 1);
    load_at(7, 10, 11);
    end_test("t3", 21);

    // 4: sync at edge 7 captures phase 6 and restarts the period
    start_test();
    push(3, 0, 1); push(6, 0, 1); push(7, 1, 1, 0, 1, 6);
    push(10, 0, 1); push(13, 0, 1); push(16, 0, 1); push(17, 1, 1);
    goto(6);
    sync_in = 1'b1;
    goto(7);
    sync_in = 1'b0;
    check("phase_after_sync", phase, 0);
    end_test("t4", 18);

    // 5: hold over edges 5-8
    start_test();
    push(3, 0, 1); push(10, 0, 1); push(13, 0, 1); push(14, 1, 1);
    goto(4);
    run = 1'b0;
    for (int e = 5; e <= 8; e++) begin
      goto(e);
      check($sformatf("hold_phase_k%0d", e), phase, 4);
    end
    run = 1'b1;
    goto(13);
    check("phase_k13", phase, 9);
    end_test("t5", 15);

    // 6: async reset mid-period discards a pending 5/2 load
    start_test();
    push(3, 0, 1); push(6, 0, 1);
    load_at(4, 5, 2);
    goto(6);
    check("phase_before_reset", phase, 6);
    #1 reset = 1'b0;
    #1;
    check("async_reset_pulses", {clk_enable, sub_enable, load_err, sync_valid}, 0);
    check("async_reset_phase", phase, 0);
    check("t6a_queue_empty", q.size(), 0);
    start_test();
    push_default_21();
    end_test("t6", 21);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
